// File: rtl/frame_extend_scheduler.sv
// rtl/frame_extend_scheduler.sv - frame extender sequencer: pass video through, then append padding lines after EOF
module frame_extend_scheduler #(
  parameter int FRAME_RES_X     = 1920,
  parameter int PX_WIDTH        = 10,
  parameter int MAX_EXTRA_LINES = 8,
  parameter int PAD_VALUE       = 0,
  parameter int ID_WIDTH        = 1,
  parameter int DEST_WIDTH      = 1,
  localparam int TDATA_WIDTH    = ((PX_WIDTH + 7) / 8) * 8,
  localparam int TKEEP_WIDTH    = TDATA_WIDTH / 8,
  localparam int EXTRA_W        = $clog2(MAX_EXTRA_LINES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  // upstream video (slave side)
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic                   video_i_tuser,
  input  logic                   video_i_tlast,
  input  logic [TKEEP_WIDTH-1:0] video_i_tkeep,
  input  logic [TKEEP_WIDTH-1:0] video_i_tstrb,
  input  logic [ID_WIDTH-1:0]    video_i_tid,
  input  logic [DEST_WIDTH-1:0]  video_i_tdest,
  // downstream video (master side)
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic                   video_o_tuser,
  output logic                   video_o_tlast,
  output logic [TKEEP_WIDTH-1:0] video_o_tkeep,
  output logic [TKEEP_WIDTH-1:0] video_o_tstrb,
  output logic [ID_WIDTH-1:0]    video_o_tid,
  output logic [DEST_WIDTH-1:0]  video_o_tdest,
  // control / status
  input  logic                   eof_i,
  input  logic [EXTRA_W-1:0]     extra_lines_i,
  output logic                   busy_o,
  output logic [15:0]            frames_ext_o
);

  localparam int PX_W = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;

  localparam logic [PX_W-1:0]        PX_LAST   = PX_W'(FRAME_RES_X - 1);
  localparam logic [EXTRA_W-1:0]     MAX_LINES = EXTRA_W'(MAX_EXTRA_LINES);
  localparam logic [TDATA_WIDTH-1:0] PAD_DATA  = TDATA_WIDTH'(PAD_VALUE);

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PX_W-1:0]      r_px_cnt;
  logic [EXTRA_W-1:0]   r_line_cnt;
  logic [EXTRA_W-1:0]   r_lines_q;
  logic [15:0]          r_frames_ext;

  logic [EXTRA_W-1:0]   w_extra_clamped;
  logic                 w_in_ready;
  logic                 w_ext_hs;
  logic                 w_ext_start;
  logic                 w_pad_hs;
  logic                 w_pad_eol;
  logic                 w_pad_done;

  // Requests above the supported maximum are clipped rather than rejected.
  assign w_extra_clamped = (extra_lines_i > MAX_LINES) ? MAX_LINES : extra_lines_i;

  // The input is only ever accepted in pass-through, and never while reset is held.
  assign w_in_ready  = (r_state == ST_PASS) && rst_n_i && video_o_tready;
  assign w_ext_hs    = video_i_tvalid && w_in_ready && video_i_tlast && eof_i;
  assign w_ext_start = w_ext_hs && (w_extra_clamped != '0);

  // tvalid is constant during padding, so a padding beat moves whenever downstream is ready.
  assign w_pad_hs   = (r_state == ST_PAD) && video_o_tready;
  assign w_pad_eol  = (r_px_cnt == PX_LAST);
  assign w_pad_done = w_pad_hs && w_pad_eol && (r_line_cnt == (r_lines_q - 1'b1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection and output muxing between the input stream and generated padding.
  always_comb begin
    w_state_nxt    = r_state;
    video_o_tvalid = 1'b0;
    video_o_tdata  = '0;
    video_o_tuser  = 1'b0;
    video_o_tlast  = 1'b0;
    video_o_tkeep  = '0;
    video_o_tstrb  = '0;
    video_o_tid    = '0;
    video_o_tdest  = '0;
    busy_o         = 1'b0;

    case (r_state)
      ST_PASS: begin
        video_o_tvalid = video_i_tvalid;
        video_o_tdata  = video_i_tdata;
        video_o_tuser  = video_i_tuser;
        video_o_tlast  = video_i_tlast;
        video_o_tkeep  = video_i_tkeep;
        video_o_tstrb  = video_i_tstrb;
        video_o_tid    = video_i_tid;
        video_o_tdest  = video_i_tdest;
        if (w_ext_start) begin
          w_state_nxt = ST_PAD;
        end
      end
      ST_PAD: begin
        busy_o         = 1'b1;
        video_o_tvalid = 1'b1;
        video_o_tdata  = PAD_DATA;
        video_o_tlast  = w_pad_eol;
        video_o_tkeep  = '1;
        video_o_tstrb  = '1;
        if (w_pad_done) begin
          w_state_nxt = ST_PASS;
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase

    // Reset blocks traffic in both directions even though the state is already PASS.
    if (!rst_n_i) begin
      video_o_tvalid = 1'b0;
    end
  end

  assign video_i_tready = w_in_ready;

  // Padding geometry counters: pixel within line, line within run, and the latched run length.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_px_cnt   <= '0;
      r_line_cnt <= '0;
      r_lines_q  <= '0;
    end else if (r_state == ST_PASS) begin
      if (w_ext_start) begin
        r_lines_q  <= w_extra_clamped;
        r_px_cnt   <= '0;
        r_line_cnt <= '0;
      end
    end else if (w_pad_hs) begin
      if (w_pad_eol) begin
        r_px_cnt   <= '0;
        r_line_cnt <= r_line_cnt + 1'b1;
      end else begin
        r_px_cnt   <= r_px_cnt + 1'b1;
      end
    end
  end

  // Completed padding runs; a run abandoned by reset is never counted.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_frames_ext <= '0;
    end else if (w_pad_done) begin
      r_frames_ext <= r_frames_ext + 16'd1;
    end
  end

  assign frames_ext_o = r_frames_ext;

endmodule
